// File: rtl/alu_issue_capture.sv
// Operand issue and result capture stage for the 16-bit logic slice.
// Holds operands through the evaluation window, then queues flagged results.
module alu_issue_capture #(
    parameter int LAT   = 4,
    parameter int DEPTH = 2
) (
    input  logic        clkpos,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [1:0]  req_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] or_out,
    input  logic [15:0] and_out,
    input  logic [15:0] xor_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_zero,
    output logic        res_neg,
    output logic        busy
);

    if (LAT < 1) begin : g_lat_check
        $error("alu_issue_capture: LAT must be >= 1");
    end

    if (DEPTH < 1) begin : g_depth_check
        $error("alu_issue_capture: DEPTH must be >= 1");
    end

    localparam int CTW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);

    localparam logic [CTW-1:0] CNT_LOAD  = CTW'(LAT - 1);
    localparam logic [PW-1:0]  PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0]  FIFO_FULL = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t         state;
    logic [CTW-1:0] cnt;
    logic [1:0]     op_q;

    logic [15:0]    fifo_data [DEPTH];
    logic           fifo_zero [DEPTH];
    logic           fifo_neg  [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic           accept;
    logic           capture;
    logic           pop;
    logic [15:0]    sel;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign req_ready = !rst && (state == IDLE) && (count < FIFO_FULL);
    assign accept    = req_valid && req_ready;
    assign capture   = (state == WAIT) && (cnt == '0);
    assign pop       = res_valid && res_ready;
    assign busy      = (state == WAIT);

    always_comb begin
        sel = '0;
        unique case (op_q)
            2'b00: sel = or_out;
            2'b01: sel = and_out;
            2'b10: sel = xor_out;
            2'b11: sel = ~or_out;
            default: sel = '0;
        endcase
    end

    // Operands stay on the array inputs until the next accept.
    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= 2'b00;
            alu_a <= '0;
            alu_b <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a <= req_a;
                        alu_b <= req_b;
                        op_q  <= req_op;
                        cnt   <= CNT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CTW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            unique case ({capture, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty slots are masked at the output.
    always_ff @(posedge clkpos) begin
        if (capture) begin
            fifo_data[wr_ptr] <= sel;
            fifo_zero[wr_ptr] <= (sel == 16'h0000);
            fifo_neg[wr_ptr]  <= sel[15];
        end
    end

    assign res_valid = (count != '0);
    assign res_data  = res_valid ? fifo_data[rd_ptr] : 16'h0000;
    assign res_zero  = res_valid ? fifo_zero[rd_ptr] : 1'b0;
    assign res_neg   = res_valid ? fifo_neg[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_alu_issue_capture.sv
// Bench for alu_issue_capture: transaction-level model with a result queue.
// Logic arrays are modelled combinationally from the driven operands.
module tb_alu_issue_capture;

    localparam int LAT   = 4;
    localparam int DEPTH = 2;

    logic        clkpos;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  req_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] or_out;
    logic [15:0] and_out;
    logic [15:0] xor_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_zero;
    logic        res_neg;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q [$];
    int          busy_left;
    logic [15:0] pend;
    logic [15:0] last_a;
    logic [15:0] last_b;

    alu_issue_capture #(
        .LAT  (LAT),
        .DEPTH(DEPTH)
    ) dut (
        .clkpos   (clkpos),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_op   (req_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .or_out   (or_out),
        .and_out  (and_out),
        .xor_out  (xor_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_zero (res_zero),
        .res_neg  (res_neg),
        .busy     (busy)
    );

    assign or_out  = alu_a | alu_b;
    assign and_out = alu_a & alu_b;
    assign xor_out = alu_a ^ alu_b;

    initial clkpos = 1'b0;
    always #5 clkpos = ~clkpos;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic logic [15:0] logic_op(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic [1:0]  op);
        case (op)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    function automatic logic m_ready();
        return !rst && busy_left == 0 && exp_q.size() < DEPTH;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic compare_all();
        logic [15:0] hd;
        logic        v;
        v  = exp_q.size() != 0;
        hd = v ? exp_q[0] : 16'h0000;
        check("req_ready", req_ready, m_ready());
        check("busy", busy, busy_left != 0);
        check("alu_a", alu_a, last_a);
        check("alu_b", alu_b, last_b);
        check("res_valid", res_valid, v);
        check("res_data", res_data, hd);
        check("res_zero", res_zero, v && hd == 16'h0000);
        check("res_neg", res_neg, v && hd[15]);
    endtask

    task automatic model_clear();
        exp_q.delete();
        busy_left = 0;
        last_a    = 16'h0000;
        last_b    = 16'h0000;
    endtask

    task automatic step(input logic v, input logic [15:0] a,
                        input logic [15:0] b, input logic [1:0] op,
                        input logic rr);
        logic acc;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        res_ready = rr;
        acc = v && m_ready();
        if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) exp_q.push_back(pend);
        end else if (acc) begin
            busy_left = LAT;
            pend      = logic_op(a, b, op);
            last_a    = a;
            last_b    = b;
        end
        @(posedge clkpos);
        @(negedge clkpos);
        compare_all();
    endtask

    task automatic idle(input logic rr);
        step(1'b0, rnd16(), rnd16(), 2'($urandom), rr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        #1 compare_all();
        @(posedge clkpos);
        @(negedge clkpos);
        compare_all();
        rst = 1'b0;
        #1 compare_all();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        res_ready = 1'b0;
        pend      = '0;
        model_clear();
        @(negedge clkpos);
        do_reset();

        // Basic OR issue and latency
        step(1'b1, 16'h00F0, 16'h0F00, 2'b00, 1'b0);
        check("s1_alu_a", alu_a, 16'h00F0);
        repeat (LAT) idle(1'b0);
        check("s1_data", res_data, 16'h0FF0);
        check("s1_ready", req_ready, 1'b1);

        // NOR to zero, XOR negative
        step(1'b1, 16'hFFFF, 16'hFFFF, 2'b11, 1'b1);
        repeat (LAT) idle(1'b0);
        check("s2_nor_zero", res_zero, 1'b1);
        check("s2_nor_data", res_data, 16'h0000);
        idle(1'b1);
        step(1'b1, 16'h8000, 16'h0001, 2'b10, 1'b0);
        repeat (LAT) idle(1'b0);
        check("s2_xor_data", res_data, 16'h8001);
        check("s2_xor_neg", res_neg, 1'b1);
        idle(1'b1);

        // Back-pressure fills the FIFO and blocks accepts
        repeat (3 * (LAT + 1) + 2)
            step(1'b1, rnd16(), rnd16(), 2'($urandom), 1'b0);
        check("s3_full_block", req_ready, 1'b0);
        step(1'b1, rnd16(), rnd16(), 2'($urandom), 1'b1);
        repeat (LAT + 2) step(1'b1, rnd16(), rnd16(), 2'($urandom), 1'b0);
        repeat (2 * (LAT + 1) + 2) idle(1'b1);

        // Operand churn while waiting
        step(1'b1, 16'h1234, 16'h00FF, 2'b01, 1'b1);
        repeat (LAT) step(1'b1, rnd16(), rnd16(), 2'($urandom), 1'b0);
        check("s4_data", res_data, 16'h0034);
        idle(1'b1);

        // Reset mid-operation with one result queued
        step(1'b1, rnd16(), rnd16(), 2'b01, 1'b0);
        repeat (LAT) idle(1'b0);
        step(1'b1, rnd16(), rnd16(), 2'b01, 1'b0);
        idle(1'b0);
        idle(1'b0);
        do_reset();
        repeat (LAT + 2) idle(1'b0);
        check("s5_no_result", res_valid, 1'b0);
        step(1'b1, 16'h00F0, 16'h0F00, 2'b00, 1'b0);
        repeat (LAT) idle(1'b0);
        check("s5_data", res_data, 16'h0FF0);

        // Capture coinciding with pop of a single entry
        step(1'b1, 16'hA5A5, 16'h0F0F, 2'b10, 1'b0);
        repeat (LAT - 1) idle(1'b0);
        idle(1'b1);
        check("s6_valid", res_valid, 1'b1);
        check("s6_data", res_data, 16'hAAAA);
        idle(1'b1);

        // Random traffic with occasional reset
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7, rnd16(), rnd16(),
                     2'($urandom), $urandom_range(0, 1) == 1);
            end
        end
        repeat (2 * (LAT + 1) + 2) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_capture.md
Name: alu_issue_capture

Overview:
- Operand issue and result capture stage wrapped around the 16-bit adiabatic logic slice (or16b and its sibling and/xor arrays).
- Accepts one logic request at a time and holds the operands stable on the array inputs through the multi-phase evaluation window.
- Samples the selected array output after a fixed latency, computes zero and negative flags, and queues results in a small output FIFO with valid/ready handshake.

Parameters:
- LAT, 4, clkpos edges from operand drive to result sample. Legal range >= 1; LAT=0 is an elaboration error.
- DEPTH, 2, result FIFO entries. Legal range >= 1.

Ports:
- clkpos  input  1  stage clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  stage can accept a request.
- req_a  input  16  operand A.
- req_b  input  16  operand B.
- req_op  input  2  operation select: 00 OR, 01 AND, 10 XOR, 11 NOR.
- alu_a  output  16  operand A driven to the logic arrays.
- alu_b  output  16  operand B driven to the logic arrays.
- or_out  input  16  OR array result.
- and_out  input  16  AND array result.
- xor_out  input  16  XOR array result.
- res_valid  output  1  FIFO head valid.
- res_ready  input  1  consumer accepts the head.
- res_data  output  16  FIFO head result.
- res_zero  output  1  head result == 0.
- res_neg  output  1  head result bit 15.
- busy  output  1  an operation is in flight.

Behaviour:
- Reset (rst high, asynchronous):
  - state IDLE, counter 0, FIFO count 0, op register 00.
  - alu_a, alu_b, res_data, res_zero, res_neg, res_valid, busy all 0.
  - req_ready 0 while rst is asserted.
  - Reset mid-operation discards the in-flight op and all queued results.
- FSM states: IDLE and WAIT.
- IDLE:
  - req_ready = (count < DEPTH).
  - Accept on req_valid && req_ready at edge k: register alu_a=req_a, alu_b=req_b and the op; load counter = LAT-1; go to WAIT.
- WAIT:
  - req_ready = 0, busy = 1.
  - alu_a and alu_b are held constant; they change only on an accept.
  - Counter decrements each edge.
  - On the edge where the counter is 0 (edge k+LAT): sample the result per the op (OR=or_out, AND=and_out, XOR=xor_out, NOR=~or_out), push {data, zero=(data==0), neg=data[15]} into the FIFO, return to IDLE.
- Timing:
  - Earliest next accept is edge k+LAT+1, so throughput is one op per LAT+1 cycles.
  - With an empty FIFO, res_valid rises after edge k+LAT.
  - Operand and op values from unaccepted cycles are ignored.
- FIFO:
  - Pop on res_valid && res_ready.
  - Push and pop on the same edge leaves count unchanged; the head advances correctly.
  - Push never overflows, because accept requires count < DEPTH and only one op is ever in flight.
  - When full, req_ready stays 0 until a pop.
  - Pointers wrap modulo DEPTH.
  - res_valid = (count != 0). When empty, res_data, res_zero and res_neg read 0.
  - Head contents are stable while res_valid && !res_ready.
- After reset, alu_a and alu_b hold their last issued values indefinitely while idle.

Test Plan:
1. Reset, then accept a=0x00F0, b=0x0F00, op=OR at edge 1 → alu_a=0x00F0 held through edge 5. res_valid rises after edge 5 with res_data=0x0FF0, zero=0, neg=0. req_ready is 0 for edges 2–5 and 1 after edge 5.
2. NOR with a=b=0xFFFF (or_out=0xFFFF) → res_data=0x0000, res_zero=1, res_neg=0. XOR with a=0x8000, b=0x0001 → res_data=0x8001, neg=1.
3. res_ready held 0; issue three back-to-back ops (DEPTH=2) → third accept is blocked (req_ready=0) after two results are queued. Raise res_ready for one cycle → one pop, third op accepted next cycle, and results drain in issue order.
4. Change req_a/req_b every cycle during WAIT with req_valid high → alu_a and alu_b unchanged, captured result reflects the accepted operands only.
5. Assert rst at edge k+2 of an AND op with one result already queued → all outputs 0 immediately, no result appears after release, first post-reset accept behaves as in scenario 1.
6. FIFO holds one entry, and a capture coincides with a pop → count stays 1, res_data switches to the new result the next cycle, no bubble on res_valid.
